serial_magnitude_comparator: RTL and testbench

- Sequential controller that time-shares one instance of the existing 1-bit comparator across two WIDTH-bit unsigned operands, comparing MSB-first, one bit per clock.
- Captures operands on a start handshake, steps a bit index, and latches the first non-equal decision.
- Reports a registered gt/lt/eq result with a one-cycle done pulse.
- Serves as the area-minimal magnitude compare for control paths where latency is acceptable.

---
 rtl/serial_magnitude_comparator_pkg.sv | 18 +
 rtl/serial_magnitude_comparator_onebit.sv | 15 +
 rtl/serial_magnitude_comparator.sv | 133 +++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the serial magnitude comparator.
// Holds the FSM state encoding and the bit-index width helper.
package serial_magnitude_comparator_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CMP  = 1'b1
    } state_e;

    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 32;

    // Width of the bit-index down-counter for a WIDTH-bit operand.
    function automatic int idx_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_onebit.sv
// Single-bit magnitude comparator, shared by the serial controller.
// Ports: x, y (bits in); g = x>y, l = x<y, e = x==y (outputs).
module onebit_comparator (
    input  logic x,
    input  logic y,
    output logic g,
    output logic l,
    output logic e
);

    assign g = x & ~y;
    assign l = ~x & y;
    assign e = ~(x ^ y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// MSB-first serial compare of two WIDTH-bit unsigned operands using one
// 1-bit comparator. Ports: clk, rst_n (async low), start, a, b in;
// busy, done (1-cycle pulse), gt/lt/eq (registered, held) out.
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int IW = idx_w(WIDTH);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgt_q, sgt_d;
    logic             slt_q, slt_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic bit_g, bit_l, bit_e;
    logic hit;
    logic fin;
    logic new_gt, new_lt;

    // Operands shift left each step, so the current bit is always the MSB.
    onebit_comparator u_bit (
        .x (a_q[WIDTH-1]),
        .y (b_q[WIDTH-1]),
        .g (bit_g),
        .l (bit_l),
        .e (bit_e)
    );

    assign hit = ~bit_e;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sgt_d   = sgt_q;
        slt_d   = slt_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        new_gt  = sgt_q;
        new_lt  = slt_q;
        fin     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IW'(WIDTH - 1);
                    sgt_d   = 1'b0;
                    slt_d   = 1'b0;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                // First differing bit wins; later bits cannot override.
                if (!(sgt_q | slt_q) && hit) begin
                    new_gt = bit_g;
                    new_lt = bit_l;
                end
                sgt_d = new_gt;
                slt_d = new_lt;
                fin   = (EARLY_EXIT && hit) || (idx_q == '0);
                if (fin) begin
                    gt_d    = new_gt;
                    lt_d    = new_lt;
                    eq_d    = ~(new_gt | new_lt);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q - IW'(1);
                    a_d   = a_q << 1;
                    b_d   = b_q << 1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgt_q   <= 1'b0;
            slt_q   <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgt_q   <= sgt_d;
            slt_q   <= slt_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = (state_q == ST_CMP);
    assign done = done_q;
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed-vector bench for serial_magnitude_comparator.
// Runs an EARLY_EXIT=1 and an EARLY_EXIT=0 instance side by side.
module tb_serial_magnitude_comparator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       busy1, done1, gt1, lt1, eq1;
    logic       busy0, done0, gt0, lt0, eq0;

    int cmp_n;
    int err_n;

    serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy1), .done(done1), .gt(gt1), .lt(lt1), .eq(eq1)
    );

    serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy0), .done(done0), .gt(gt0), .lt(lt0), .eq(eq0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_EQ = 3'b001;

    task automatic test_reset();
        logic [4:0] o1, o0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        o1 = {busy1, done1, gt1, lt1, eq1};
        o0 = {busy0, done0, gt0, lt0, eq0};
        cmp_n++;
        if (o1 !== 5'b0) begin
            err_n++;
            $display("FAIL reset_ee1 got=%b want=00000", o1);
        end
        cmp_n++;
        if (o0 !== 5'b0) begin
            err_n++;
            $display("FAIL reset_ee0 got=%b want=00000", o0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Start one compare; watch both instances for their done pulse.
    task automatic run_cmp(input string nm, input logic [7:0] av,
                           input logic [7:0] bv, input int k1e,
                           input int k0e, input logic [2:0] re);
        int k1, k0, n1, n0;
        k1 = 0; k0 = 0; n1 = 0; n0 = 0;
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (done1) begin
                n1++;
                if (k1 == 0) k1 = k;
            end
            if (done0) begin
                n0++;
                if (k0 == 0) k0 = k;
            end
        end
        cmp_n++;
        if (k1 !== k1e || n1 !== 1) begin
            err_n++;
            $display("FAIL %s lat_ee1 got=%0d n=%0d want=%0d",
                     nm, k1, n1, k1e);
        end
        cmp_n++;
        if (k0 !== k0e || n0 !== 1) begin
            err_n++;
            $display("FAIL %s lat_ee0 got=%0d n=%0d want=%0d",
                     nm, k0, n0, k0e);
        end
        cmp_n++;
        if ({gt1, lt1, eq1} !== re) begin
            err_n++;
            $display("FAIL %s res_ee1 got=%b want=%b",
                     nm, {gt1, lt1, eq1}, re);
        end
        cmp_n++;
        if ({gt0, lt0, eq0} !== re) begin
            err_n++;
            $display("FAIL %s res_ee0 got=%b want=%b",
                     nm, {gt0, lt0, eq0}, re);
        end
    endtask

    task automatic test_busy_window();
        a = 8'hA5;
        b = 8'h25;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cmp_n++;
        if ({busy1, done1} !== 2'b10) begin
            err_n++;
            $display("FAIL busy_e0 got=%b want=10", {busy1, done1});
        end
        @(posedge clk);
        #1;
        cmp_n++;
        if ({busy1, done1} !== 2'b01) begin
            err_n++;
            $display("FAIL busy_e1 got=%b want=01", {busy1, done1});
        end
        @(posedge clk);
        #1;
        cmp_n++;
        if (done1 !== 1'b0) begin
            err_n++;
            $display("FAIL done_width got=%b want=0", done1);
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_start();
        int k1, n1, n0;
        k1 = 0; n1 = 0; n0 = 0;
        a = 8'h3C;
        b = 8'h3D;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                a = 8'hFF;
                b = 8'h00;
                start = 1'b1;
            end
            if (k == 3) start = 1'b0;
            if (done1) begin
                n1++;
                if (k1 == 0) k1 = k;
            end
            if (done0) n0++;
        end
        cmp_n++;
        if (k1 !== 8 || n1 !== 1) begin
            err_n++;
            $display("FAIL ignore_lat got=%0d n=%0d want=8 n=1", k1, n1);
        end
        cmp_n++;
        if (n0 !== 1) begin
            err_n++;
            $display("FAIL ignore_ee0_n got=%0d want=1", n0);
        end
        cmp_n++;
        if ({gt1, lt1, eq1} !== R_LT) begin
            err_n++;
            $display("FAIL ignore_res got=%b want=%b", {gt1, lt1, eq1}, R_LT);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        a = 8'hA5;
        b = 8'h25;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h01;
        b = 8'h02;
        @(posedge clk);
        #1;
        cmp_n++;
        if ({done1, gt1, lt1, eq1} !== 4'b1100) begin
            err_n++;
            $display("FAIL b2b_first got=%b want=1100",
                     {done1, gt1, lt1, eq1});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        cmp_n++;
        if ({busy1, done1} !== 2'b10) begin
            err_n++;
            $display("FAIL b2b_accept got=%b want=10", {busy1, done1});
        end
        for (int k = 3; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if ({done1, gt1, lt1, eq1} !== 4'b0100) bad++;
        end
        cmp_n++;
        if (bad !== 0) begin
            err_n++;
            $display("FAIL b2b_hold got=%0d bad cycles want=0", bad);
        end
        @(posedge clk);
        #1;
        cmp_n++;
        if ({done1, gt1, lt1, eq1} !== 4'b1010) begin
            err_n++;
            $display("FAIL b2b_second got=%b want=1010",
                     {done1, gt1, lt1, eq1});
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        a = 8'h0F;
        b = 8'h0E;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp_n++;
        if ({busy1, busy0, lt1} !== 3'b111) begin
            err_n++;
            $display("FAIL arst_pre got=%b want=111", {busy1, busy0, lt1});
        end
        #2;
        rst_n = 1'b0;
        #1;
        cmp_n++;
        if ({busy1, done1, gt1, lt1, eq1} !== 5'b0) begin
            err_n++;
            $display("FAIL arst_ee1 got=%b want=00000",
                     {busy1, done1, gt1, lt1, eq1});
        end
        cmp_n++;
        if ({busy0, done0, gt0, lt0, eq0} !== 5'b0) begin
            err_n++;
            $display("FAIL arst_ee0 got=%b want=00000",
                     {busy0, done0, gt0, lt0, eq0});
        end
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done1 || done0 || busy1 || busy0) n++;
        end
        cmp_n++;
        if (n !== 0) begin
            err_n++;
            $display("FAIL arst_quiet got=%0d active cycles want=0", n);
        end
        run_cmp("arst_fresh", 8'h10, 8'h10, 8, 8, R_EQ);
    endtask

    initial begin
        cmp_n = 0;
        err_n = 0;
        test_reset();
        test_busy_window();
        run_cmp("a5_25", 8'hA5, 8'h25, 1, 8, R_GT);
        run_cmp("3c_3d", 8'h3C, 8'h3D, 8, 8, R_LT);
        run_cmp("5a_5a", 8'h5A, 8'h5A, 8, 8, R_EQ);
        run_cmp("80_00", 8'h80, 8'h00, 1, 8, R_GT);
        run_cmp("80_7f", 8'h80, 8'h7F, 1, 8, R_GT);
        run_cmp("00_ff", 8'h00, 8'hFF, 1, 8, R_LT);
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_n, err_n);
        $finish;
    end

endmodule
